// File: rtl/shift_pkg.sv
// Shared definitions for the barrel-shifter command front-end.
package shift_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned SW_DEF    = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/shift_cmd_sequencer.sv
// Drives a combinational barrel shifter from registered A/S, returning each result
// over a back-pressured handshake; sweep mode steps S up to WIDTH-1.
module shift_cmd_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SW    = SW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic             in_sweep,
    output logic [WIDTH-1:0] shf_a,
    output logic [SW-1:0]    shf_s,
    input  logic [WIDTH-1:0] shf_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_amt,
    output logic             out_last,
    output logic             busy
);

    logic [0:0]       state_q, state_d;
    logic             sweep_q, sweep_d;
    logic [WIDTH-1:0] shf_a_q, shf_a_d;
    logic [SW-1:0]    shf_s_q, shf_s_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_amt_q, out_amt_d;
    logic             out_last_q, out_last_d;

    logic can_cap;
    logic is_last;

    // The output slot is free when empty or being drained this cycle.
    assign can_cap  = !out_valid_q || out_ready;
    assign is_last  = !sweep_q || (shf_s_q == SW'(WIDTH - 1));
    assign in_ready = (state_q == IDLE) && can_cap;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        shf_a_d     = shf_a_q;
        shf_s_d     = shf_s_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_amt_d   = out_amt_q;
        out_last_d  = out_last_q;

        if (state_q == IDLE) begin
            if (in_valid && in_ready) begin
                shf_a_d = in_data;
                shf_s_d = in_amt;
                sweep_d = in_sweep;
                state_d = RUN;
            end
        end else if (can_cap) begin
            out_valid_d = 1'b1;
            out_data_d  = shf_y;
            out_amt_d   = shf_s_q;
            out_last_d  = is_last;
            if (is_last) begin
                state_d = IDLE;
            end else begin
                shf_s_d = shf_s_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sweep_q     <= 1'b0;
            shf_a_q     <= '0;
            shf_s_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            shf_a_q     <= shf_a_d;
            shf_s_q     <= shf_s_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_amt_q   <= out_amt_d;
            out_last_q  <= out_last_d;
        end
    end

    assign shf_a     = shf_a_q;
    assign shf_s     = shf_s_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_amt   = out_amt_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed and randomised checks of the shift command sequencer against a rotate-left shifter.
module tb_shift_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_sweep;
    logic [7:0] shf_a;
    logic [2:0] shf_s;
    logic [7:0] shf_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
        logic       l;
    } exp_t;

    exp_t exp_q[$];

    // Rotations of 8'h4E by 0..7, worked by hand.
    logic [7:0] rol4e [8] = '{8'h4E, 8'h9C, 8'h39, 8'h72, 8'hE4, 8'hC9, 8'h93, 8'h27};

    // Stand-in for the existing combinational shifter: rotate left.
    function automatic logic [7:0] rol(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    assign shf_y = rol(shf_a, shf_s);

    shift_cmd_sequencer #(.WIDTH(8), .SW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_sweep  (in_sweep),
        .shf_a     (shf_a),
        .shf_s     (shf_s),
        .shf_y     (shf_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_sweep = 1'b0; out_ready = 1'b1;
        #12;
        checks++;
        if ({out_valid, out_data, out_amt, out_last, shf_a, shf_s, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h a=%0d l=%b sa=%h ss=%0d busy=%b exp all 0",
                     out_valid, out_data, out_amt, out_last, shf_a, shf_s, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'h4E; in_amt = 3'd3; in_sweep = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || shf_a !== 8'h4E || shf_s !== 3'd3) begin
            errors++;
            $display("FAIL single_load got v=%b a=%h s=%0d exp v=0 a=4e s=3", out_valid, shf_a, shf_s);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h72 || out_amt !== 3'd3 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_result got v=%b d=%h a=%0d l=%b exp v=1 d=72 a=3 l=1",
                     out_valid, out_data, out_amt, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got v=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_sweep();
        in_valid = 1'b1; in_data = 8'h4E; in_amt = 3'd0; in_sweep = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_amt !== 3'(i) || out_data !== rol4e[i] ||
                out_last !== (i == 7) || in_ready !== (i == 7)) begin
                errors++;
                $display("FAIL sweep_step%0d got v=%b a=%0d d=%h l=%b rdy=%b exp v=1 a=%0d d=%h l=%b rdy=%b",
                         i, out_valid, out_amt, out_data, out_last, in_ready, i, rol4e[i], i == 7, i == 7);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_end got v=%b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 8'h4E; in_amt = 3'd5; in_sweep = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_amt !== 3'd5 || out_data !== 8'hC9 || out_last !== 1'b0 ||
                shf_s !== 3'd6 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b a=%0d d=%h l=%b s=%0d rdy=%b exp v=1 a=5 d=c9 l=0 s=6 rdy=0",
                         i, out_valid, out_amt, out_data, out_last, shf_s, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_amt !== 3'd6 || out_data !== 8'h93 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_amt6 got v=%b a=%0d d=%h l=%b exp v=1 a=6 d=93 l=0", out_valid, out_amt, out_data, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_amt !== 3'd7 || out_data !== 8'h27 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_amt7 got v=%b a=%0d d=%h l=%b exp v=1 a=7 d=27 l=1", out_valid, out_amt, out_data, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got v=%b exp 0", out_valid); end
    endtask

    task automatic test_edge();
        in_valid = 1'b1; in_data = 8'h4E; in_amt = 3'd7; in_sweep = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_amt !== 3'd7 || out_data !== 8'h27 || out_last !== 1'b1 ||
            in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_result got v=%b a=%0d d=%h l=%b rdy=%b busy=%b exp v=1 a=7 d=27 l=1 rdy=0 busy=1",
                     out_valid, out_amt, out_data, out_last, in_ready, busy);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_sweep = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL edge_ready_on_pop got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || shf_a !== 8'h81 || shf_s !== 3'd1) begin
            errors++;
            $display("FAIL edge_accept got v=%b a=%h s=%0d exp v=0 a=81 s=1", out_valid, shf_a, shf_s);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_amt !== 3'd1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL edge_next got v=%b d=%h a=%0d l=%b exp v=1 d=03 a=1 l=1", out_valid, out_data, out_amt, out_last);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h4E; in_amt = 3'd0; in_sweep = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (out_amt !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got a=%0d v=%b exp a=3 v=1", out_amt, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || shf_a !== 8'h00 || shf_s !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b a=%h s=%0d busy=%b exp 0 00 0 0", out_valid, shf_a, shf_s, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || shf_s !== 3'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_after%0d got v=%b rdy=%b s=%0d busy=%b exp v=0 rdy=1 s=0 busy=0",
                         i, out_valid, in_ready, shf_s, busy);
            end
        end
    endtask

    task automatic test_random();
        logic pend;
        int   expected_total;
        int   got_total;
        int   guard;
        pend = 1'b0; expected_total = 0; got_total = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pend && ($urandom_range(0, 2) == 0)) begin
                pend = 1'b1;
                in_data = 8'($urandom);
                in_amt = 3'($urandom_range(0, 7));
                in_sweep = 1'($urandom_range(0, 1));
            end
            in_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                pend = 1'b0;
                if (in_sweep) begin
                    for (int unsigned k = in_amt; k < 8; k++) begin
                        exp_q.push_back('{rol(in_data, 3'(k)), 3'(k), k == 7});
                        expected_total++;
                    end
                end else begin
                    exp_q.push_back('{rol(in_data, in_amt), in_amt, 1'b1});
                    expected_total++;
                end
            end
            if (out_valid && out_ready) begin
                got_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got d=%h a=%0d exp no result", out_data, out_amt);
                end else begin
                    if (out_data !== exp_q[0].d || out_amt !== exp_q[0].a || out_last !== exp_q[0].l) begin
                        errors++;
                        $display("FAIL rand_result got d=%h a=%0d l=%b exp d=%h a=%0d l=%b",
                                 out_data, out_amt, out_last, exp_q[0].d, exp_q[0].a, exp_q[0].l);
                    end
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 50) begin
            #1;
            if (out_valid && out_ready) begin
                got_total++;
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0].d || out_amt !== exp_q[0].a ||
                    out_last !== exp_q[0].l) begin
                    errors++;
                    $display("FAIL rand_drain got d=%h a=%0d l=%b queued=%0d", out_data, out_amt, out_last, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (got_total !== expected_total || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_count got %0d busy=%b exp %0d busy=0", got_total, busy, expected_total);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
